pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32 core. It decodes register-source usage of the ID-stage instruction (R/I/load/store/branch formats), detects load-use hazards against EX, and flushes on a taken branch resolved in EX. It freezes the whole pipeline while data memory is not ready, with a watchdog that halts the core on a memory timeout. It drives the PC enable and every pipeline-register enable and flush.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles on a pending data access before the core halts (legal range 2..65535)
CNT_W, 32, width of the performance counters (used only with HAZ_PERF_CNT_EN)

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
id_inst  in  32  instruction currently in IF/ID
id_valid  in  1  IF/ID holds a real instruction (not a bubble)
ex_valid  in  1  ID/EX holds a real instruction
ex_memread  in  1  EX instruction is a load
ex_rd  in  5  EX destination register
ex_branch_taken  in  1  branch in EX resolved taken this cycle
mem_req  in  1  MEM stage performs a data access this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to bubble
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX clear to bubble
exmem_en  out  1  EX/MEM load enable
memwb_en  out  1  MEM/WB load enable
mem_timeout  out  1  sticky error flag, registered
stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  performance counters

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN. Wait counter resets to 0. mem_timeout resets to 0.
- While rst_n is low, all enables are 0, all flushes are 0, and all counters are 0.
- Control outputs are combinational from state and inputs, giving zero-cycle hazard response. mem_timeout is a flop.
- Source usage from id_inst[6:0]:
  - 0110011, 0100011, 1100011: use rs1 (inst[19:15]) and rs2 (inst[24:20]).
  - 0010011, 0000011: use rs1 only.
  - Any other opcode: no sources.
  - id_valid=0: no sources.
- load_use = ex_valid & ex_memread & (ex_rd!=0) & (ex_rd matches a used source). x0 never causes a hazard.
- Freeze condition: state==HALT, or state==MEM_WAIT with mem_ready=0, or state==RUN with mem_req=1 and mem_ready=0. During freeze, every enable is 0 and every flush is 0.
- When not frozen, priority is:
  - ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1, other enables 1. This overrides load_use.
  - load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. Exactly one bubble is inserted.
  - Otherwise: all enables 1, no flush.
- Flush has priority over enable on the same register.
- RUN -> MEM_WAIT when mem_req=1 and mem_ready=0. The wait counter loads 1.
- MEM_WAIT with mem_ready=1: pipeline releases this same cycle under normal priority; next state RUN; counter cleared.
- MEM_WAIT with mem_ready=0: counter increments. When the counter reaches MEM_TIMEOUT, the next state is HALT and mem_timeout is set.
- Timing of timeout: mem_timeout rises on the edge after the MEM_TIMEOUT-th consecutive not-ready cycle.
- HALT is absorbing. The core stays frozen and mem_timeout stays 1 until rst_n.
- mem_req drop while in MEM_WAIT is treated as ready: release and return to RUN.
- Reset asserted mid-wait returns to RUN immediately and clears the counter and mem_timeout.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments on each load_use bubble.
  - flush_cnt increments on each taken-branch flush.
  - wait_cnt increments on each frozen cycle.
  - All three wrap modulo 2^CNT_W and clear on reset.
- Not defined: the counter ports remain, tied to 0, with no counter flops.

Decomposition:
- hazard_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - the state typedef {RUN, MEM_WAIT, HALT};
  - the rs1/rs2 bit-field positions.
- One sub-module, rs_use_decode: combinational id_inst/id_valid -> rs1, rs2, use_rs1, use_rs2.

Test Plan:
- Load-use: EX lw x5 (ex_memread=1, ex_rd=5), ID add x6,x5,x7 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle all enables 1.
- No false hazard:
  - ex_rd=0 with ID add x1,x0,x0 -> no stall.
  - ex_rd=5 with ID addi x6,x7,1 -> no stall.
  - ex_rd=5 with ID lui-class opcode 0110111 -> no stall.
- Branch over load-use: ex_branch_taken=1 together with load_use -> pc_en=1, ifid_flush=1, idex_flush=1, no stall. flush_cnt +1 with HAZ_PERF_CNT_EN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, released in cycle 4, state back to RUN, wait_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th cycle, state HALT. Later mem_ready=1 still frozen. rst_n pulse clears everything.
- Reset mid-wait: rst_n low during MEM_WAIT -> outputs 0 asynchronously. After release: RUN, counter 0, mem_timeout 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcode, register-field and FSM-state definitions for the RV32 pipeline hazard controller.
package hazard_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int OPC_W   = 7;
    localparam int RS_W    = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_e;

endpackage

// File: rtl/rs_use_decode.sv
// Decodes which register sources the IF/ID instruction actually reads.
module rs_use_decode
    import hazard_pkg::*;
(
    input  logic [31:0]     inst,
    input  logic            valid,
    output logic [RS_W-1:0] rs1,
    output logic [RS_W-1:0] rs2,
    output logic            use_rs1,
    output logic            use_rs2
);

    logic unused_fields;
    assign unused_fields = ^{inst[31:25], inst[14:7]};

    assign rs1 = inst[RS1_LSB +: RS_W];
    assign rs2 = inst[RS2_LSB +: RS_W];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (valid) begin
            case (inst[OPC_W-1:0])
                OP_R, OP_STORE, OP_BRANCH: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_IMM, OP_LOAD: use_rs1 = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch-flush / memory-freeze controller for the 5-stage RV32 pipeline.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
//
// state    | meaning
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | data access pending, pipeline frozen until ready or timeout
// HALT     | memory watchdog expired; frozen until reset
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int WLEN_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WLEN_W-1:0] WLEN_LAST = WLEN_W'(MEM_TIMEOUT - 1);
    localparam logic [WLEN_W-1:0] WLEN_MAX  = WLEN_W'(MEM_TIMEOUT);
    localparam logic [WLEN_W-1:0] WLEN_ONE  = WLEN_W'(1);

    hz_state_e        state;
    logic [WLEN_W-1:0] wait_len;

    logic [RS_W-1:0] rs1;
    logic [RS_W-1:0] rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            load_use;
    logic            wait_done;
    logic            frozen;

    rs_use_decode u_rs_use_decode (
        .inst    (id_inst),
        .valid   (id_valid),
        .rs1     (rs1),
        .rs2     (rs2),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign load_use = ex_valid && ex_memread && (ex_rd != '0) &&
                      ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

    // A dropped request while waiting counts as completion.
    assign wait_done = mem_ready || !mem_req;

    assign frozen = (state == HALT) ||
                    ((state == MEM_WAIT) && !wait_done) ||
                    ((state == RUN) && mem_req && !mem_ready);

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        if (rst_n && !frozen) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_len    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_len <= WLEN_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (wait_done) begin
                        state    <= RUN;
                        wait_len <= '0;
                    end else if (wait_len == WLEN_LAST) begin
                        state       <= HALT;
                        wait_len    <= WLEN_MAX;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_len <= wait_len + WLEN_ONE;
                    end
                end
                HALT: ;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic stall_ev;
    logic flush_ev;

    assign stall_ev = !frozen && !ex_branch_taken && load_use;
    assign flush_ev = !frozen && ex_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_ev) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev) flush_cnt <= flush_cnt + CNT_W'(1);
            if (frozen)   wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard/wait/timeout steps plus randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_inst = '0;
    logic        id_valid = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic        mem_timeout;
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
    logic [6:0]  ctrl;

    int checks = 0;
    int failures = 0;

    // Reference model: consecutive not-ready count, halt flag, event tallies
    int          nr = 0;
    bit          halted = 1'b0;
    int unsigned m_stall = 0, m_flush = 0, m_wait = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .wait_cnt(wait_cnt)
    );

    assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
        return {7'b0000000, r2, r1, 3'b000, 5'd1, op};
    endfunction

    function automatic bit hazard_ref(input logic [31:0] inst, input bit idv, input bit exv,
                                      input bit exmr, input logic [4:0] exrd);
        logic [6:0] op;
        bit two, one;
        op  = inst[6:0];
        two = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        one = two || (op inside {7'b0010011, 7'b0000011});
        if (!idv || !exv || !exmr || exrd == 5'd0) return 1'b0;
        return (one && inst[19:15] == exrd) || (two && inst[24:20] == exrd);
    endfunction

    task automatic check_counters(input string tag);
`ifdef HAZ_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cnt, m_stall);
        chk({tag, "_flush_cnt"}, flush_cnt, m_flush);
        chk({tag, "_wait_cnt"},  wait_cnt,  m_wait);
`else
        chk({tag, "_cnt_tied"}, stall_cnt | flush_cnt | wait_cnt, 32'd0);
`endif
    endtask

    // Called at a falling edge; leaves time at the next falling edge.
    task automatic step(input string tag, input logic [31:0] inst, input bit idv, input bit exv,
                        input bit exmr, input logic [4:0] exrd, input bit br,
                        input bit mreq, input bit mrdy);
        bit frozen, hz;
        logic [6:0] exp;
        id_inst = inst; id_valid = idv; ex_valid = exv; ex_memread = exmr;
        ex_rd = exrd; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        #1;
        frozen = halted || (mreq && !mrdy);
        hz = hazard_ref(inst, idv, exv, exmr, exrd);
        if (frozen)  exp = 7'b0000000;
        else if (br) exp = 7'b1111111;
        else if (hz) exp = 7'b0001111;
        else         exp = 7'b1101011;
        chk({tag, "_ctrl"}, {25'd0, ctrl}, {25'd0, exp});
        if (frozen)  m_wait++;
        else if (br) m_flush++;
        else if (hz) m_stall++;
        if (!halted) begin
            if (mreq && !mrdy) begin
                nr++;
                if (nr >= TO) halted = 1'b1;
            end else begin
                nr = 0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, halted});
        check_counters(tag);
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with whatever inputs are applied; outputs must drop at once.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_ctrl"}, {25'd0, ctrl}, 32'd0);
        chk({tag, "_rst_timeout"}, {31'd0, mem_timeout}, 32'd0);
        chk({tag, "_rst_cnt"}, stall_cnt | flush_cnt | wait_cnt, 32'd0);
        nr = 0; halted = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] inst;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b1101111, 7'b0010111};

        // Reset state with active-looking inputs
        id_inst = mk(7'b0110011, 5'd5, 5'd7); id_valid = 1; ex_valid = 1; ex_memread = 1;
        ex_rd = 5'd5; mem_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", {25'd0, ctrl}, 32'd0);
        chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("reset_cnt", stall_cnt | flush_cnt | wait_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load-use bubble then recovery
        step("lu_add",       mk(7'b0110011, 5'd5, 5'd7), 1, 1, 1, 5'd5, 0, 0, 0);
        step("lu_next",      mk(7'b0110011, 5'd5, 5'd7), 1, 0, 0, 5'd0, 0, 0, 0);
        step("lu_rs2",       mk(7'b0100011, 5'd9, 5'd5), 1, 1, 1, 5'd5, 0, 0, 0);
        // No false hazards
        step("x0_no_stall",  mk(7'b0110011, 5'd0, 5'd0), 1, 1, 1, 5'd0, 0, 0, 0);
        step("addi_rs2fld",  mk(7'b0010011, 5'd7, 5'd5), 1, 1, 1, 5'd5, 0, 0, 0);
        step("lui_no_src",   mk(7'b0110111, 5'd5, 5'd5), 1, 1, 1, 5'd5, 0, 0, 0);
        step("id_bubble",    mk(7'b0110011, 5'd5, 5'd5), 0, 1, 1, 5'd5, 0, 0, 0);
        step("ex_not_load",  mk(7'b0110011, 5'd5, 5'd5), 1, 1, 0, 5'd5, 0, 0, 0);
        // Branch overrides load-use
        step("br_over_lu",   mk(7'b0110011, 5'd5, 5'd7), 1, 1, 1, 5'd5, 1, 0, 0);
        // Memory wait of 3 cycles, released on the 4th
        step("mw1", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("mw2", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("mw3", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("mw_rel", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 1);
        step("mw_run", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 0, 0);
        // Request dropped while waiting
        step("drop1", mk(7'b0010011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("drop_rel", mk(7'b0010011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 0, 0);
        // Timeout after TO not-ready cycles, then absorbing halt
        for (int i = 0; i < TO; i++)
            step("to_wait", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("halt_ready", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 1);
        step("halt_branch", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 1, 0, 0);
        pulse_reset("halt");
        step("after_halt", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 0, 0);
        // Reset mid-wait clears the watchdog count
        step("mid1", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("mid2", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        pulse_reset("mid");
        for (int i = 0; i < TO - 1; i++)
            step("post_mid_wait", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 0);
        step("post_mid_rel", mk(7'b0110011, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            inst = $urandom;
            inst[6:0]   = ops[$urandom_range(0, 7)];
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) pulse_reset("rnd");
            step("rnd", inst, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
